// File: rtl/cal_flags_reg.sv
// cal_flags_reg: registered NZCV flag unit behind the ALU result stage.
// Captures flags on a valid/write-enable handshake, keeps sticky carry and
// overflow status with a saturating overflow-event counter, and evaluates a
// 4-bit condition code against the held flags.
module cal_flags_reg #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             valid_in,
    input  logic             flag_we,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] result,
    input  logic             co_add,
    input  logic             cm_add,
    input  logic             sticky_clr,
    input  logic [3:0]       cond,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             valid_out,
    output logic             sticky_c,
    output logic             sticky_v,
    output logic [CNT_W-1:0] ovf_cnt,
    output logic             cond_true
);

    logic arith;
    logic upd;
    logic c_new;
    logic v_new;
    logic n_new;
    logic z_new;

    // Next-flag values derived from the current ALU result and adder carries
    always_comb begin
        arith = (op == 3'b110) || (op == 3'b111);
        upd   = valid_in & flag_we;
        n_new = result[WIDTH-1];
        z_new = (result == '0);
        c_new = arith ? co_add : 1'b0;
        v_new = arith ? (co_add ^ cm_add) : 1'b0;
    end

    // Flag register: loads on an accepted update, otherwise holds
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            c <= 1'b0;
            n <= 1'b0;
            z <= 1'b0;
            v <= 1'b0;
        end else if (upd) begin
            c <= c_new;
            n <= n_new;
            z <= z_new;
            v <= v_new;
        end
    end

    // Valid pipeline stage, independent of flag_we
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_out <= 1'b0;
        end else begin
            valid_out <= valid_in;
        end
    end

    // Sticky status; a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sticky_c <= 1'b0;
            sticky_v <= 1'b0;
        end else begin
            sticky_c <= (sticky_c & ~sticky_clr) | (upd & c_new);
            sticky_v <= (sticky_v & ~sticky_clr) | (upd & v_new);
        end
    end

    // Saturating overflow-event counter; clear reloads with the current event
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt <= '0;
        end else if (sticky_clr) begin
            ovf_cnt <= (upd & v_new) ? CNT_W'(1) : '0;
        end else if (upd & v_new) begin
            if (ovf_cnt != '1) begin
                ovf_cnt <= ovf_cnt + CNT_W'(1);
            end
        end
    end

    // Condition-code evaluation against the registered flags only
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            4'd0:  cond_true = z;
            4'd1:  cond_true = ~z;
            4'd2:  cond_true = c;
            4'd3:  cond_true = ~c;
            4'd4:  cond_true = n;
            4'd5:  cond_true = ~n;
            4'd6:  cond_true = v;
            4'd7:  cond_true = ~v;
            4'd8:  cond_true = c & ~z;
            4'd9:  cond_true = ~c | z;
            4'd10: cond_true = (n == v);
            4'd11: cond_true = (n != v);
            4'd12: cond_true = ~z & (n == v);
            4'd13: cond_true = z | (n != v);
            4'd14: cond_true = 1'b1;
            4'd15: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end

endmodule

// File: doc/cal_flags_reg.md
Name: cal_flags_reg

Overview:
Registered, width-parametrised NZCV flag unit that follows the ALU result stage. It captures flags from an ALU result under a valid/write-enable handshake. It keeps sticky carry and overflow status with a saturating overflow-event counter. It evaluates a 4-bit condition code against the held flags for branch/select logic.

Parameters:
WIDTH, 8, ALU result width in bits; legal range ≥2.
CNT_W, 4, width of the overflow-event counter; legal range ≥1.

Ports:
clk  input  1  system clock, rising edge.
reset_n  input  1  asynchronous active-low reset.
valid_in  input  1  ALU result and carries are valid this cycle.
flag_we  input  1  flags update permitted; qualified by valid_in.
op  input  3  ALU opcode; op[2:1]==2'b11 means arithmetic (110 add, 111 sub); all other codes are logical/shift.
result  input  WIDTH  ALU result.
co_add  input  1  carry out of the MSB of the adder.
cm_add  input  1  carry into the MSB of the adder.
sticky_clr  input  1  clear sticky_c, sticky_v and ovf_cnt.
cond  input  4  condition code to evaluate.
c  output  1  registered carry flag.
n  output  1  registered negative flag.
z  output  1  registered zero flag.
v  output  1  registered overflow flag.
valid_out  output  1  one-cycle pulse, one cycle after valid_in.
sticky_c  output  1  accumulated carry since the last clear.
sticky_v  output  1  accumulated overflow since the last clear.
ovf_cnt  output  CNT_W  saturating count of overflow events.
cond_true  output  1  combinational evaluation of cond against the registered flags.

Behaviour:
- Reset (reset_n=0, asynchronous): c, n, z, v, valid_out, sticky_c, sticky_v all 0; ovf_cnt=0. Reset asserted mid-operation discards any in-flight update.
- Next-flag computation (combinational):
  - n_new = result[WIDTH-1]
  - z_new = (result == 0)
  - c_new = arith ? co_add : 0
  - v_new = arith ? (co_add ^ cm_add) : 0
  - arith = (op[2:1]==2'b11)
- Update event: upd = valid_in & flag_we. On upd, c/n/z/v load the new values at the next clock edge (latency 1). Otherwise they hold.
- valid_out <= valid_in every cycle, independent of flag_we.
- sticky_c <= (sticky_c & ~sticky_clr) | (upd & c_new). sticky_v is computed the same way with v_new. When a clear and a set occur in the same cycle, the set wins.
- ovf_cnt:
  - If sticky_clr: load (upd & v_new) ? 1 : 0.
  - Else if upd & v_new: increment, saturating at 2^CNT_W-1 (no wrap).
  - Else hold.
- cond_true is a function of the registered flags only, with zero latency from cond:
  - 0 EQ z; 1 NE !z
  - 2 CS c; 3 CC !c
  - 4 MI n; 5 PL !n
  - 6 VS v; 7 VC !v
  - 8 HI c&!z; 9 LS !c|z
  - 10 GE n==v; 11 LT n!=v
  - 12 GT !z&(n==v); 13 LE z|(n!=v)
  - 14 AL 1; 15 NV 0
- A flag update issued at cycle t is visible to cond_true from cycle t+1. Back-to-back updates are accepted every cycle with no stall.
- flag_we with valid_in=0 has no effect.

Test Plan:
- Reset, WIDTH=8: assert reset_n=0 asynchronously between edges -> all outputs 0 immediately; cond=14 -> cond_true=1, cond=0 -> cond_true=0.
- Signed overflow: op=110, result=0x80, co_add=0, cm_add=1, valid_in=flag_we=1 -> next cycle n=1, z=0, c=0, v=1, valid_out=1, sticky_v=1, ovf_cnt=1; cond=11 (LT) -> 0, cond=6 -> 1.
- Logic op zero: op=010, result=0x00, co_add=1, cm_add=0 -> c=0, v=0, z=1, n=0; sticky_v unchanged; cond=0 -> 1, cond=8 -> 0.
- Hold: valid_in=1, flag_we=0, result=0xFF -> flags unchanged, valid_out pulses 1, ovf_cnt unchanged.
- Saturation, CNT_W=4: 17 consecutive overflow updates (op=111, result=0x7F, co_add=1, cm_add=0) -> ovf_cnt reaches 15 and stays 15; sticky_clr alone -> ovf_cnt=0, sticky_v=0 next cycle.
- Simultaneous clear and overflow: sticky_clr=1 with an overflow update in the same cycle -> sticky_v=1, ovf_cnt=1; sticky_clr with a carry-only add (co_add=1, cm_add=1) -> sticky_c=1, sticky_v=0, ovf_cnt=0.
